range_gen: RTL and testbench

RANGE_GEN -- requirements
Module: range_gen

---
 rtl/range_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_range_gen.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_gen.sv
// ---------------------------------------------------------------------------
// range_gen
//
// Generates values in the half-open range [LOWER_BOUND, UPPER_BOUND) over a
// valid/ready handshake.  Three generation orders are available:
//   METHOD 0 : ascending sweep LOWER_BOUND .. UPPER_BOUND-1, then repeat
//   METHOD 1 : descending sweep UPPER_BOUND-1 .. LOWER_BOUND, then repeat
//   METHOD 2 : pseudo-random, low WIDTH bits of a 16-bit Fibonacci LFSR
//              (taps 16,14,13,11, seed 16'hACE1), out-of-range candidates
//              are dropped
// With ONE_SHOT=1 the block parks in DONE after one pass (METHOD 0/1) or
// after UPPER_BOUND-LOWER_BOUND accepted values (METHOD 2).
//
// Ports
//   clk   : rising-edge clock
//   arst  : asynchronous active-high reset
//   start : leave IDLE/DONE and begin generating (ignored in RUN)
//   halt  : return to IDLE; wins over start and over an acceptance
//   dat   : generated value (registered)
//   valid : dat holds a legal value (registered)
//   ready : consumer accepts dat when valid is high
//   busy  : high in RUN
//   wrap  : one-cycle pulse after the last value of a pass is accepted
//   done  : level, high in DONE
// ---------------------------------------------------------------------------
module range_gen #(
    parameter int WIDTH       = 7,
    parameter int LOWER_BOUND = 85,
    parameter int UPPER_BOUND = 120,
    parameter int METHOD      = 0,
    parameter int ONE_SHOT    = 0
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic             halt,
    output logic [WIDTH-1:0] dat,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    localparam int SPAN = UPPER_BOUND - LOWER_BOUND;
    localparam int CW   = $clog2(SPAN + 1);

    localparam logic [WIDTH-1:0] LO_W  = WIDTH'(LOWER_BOUND);
    localparam logic [WIDTH-1:0] HI_W  = WIDTH'(UPPER_BOUND - 1);
    localparam logic [WIDTH-1:0] FIRST = (METHOD == 1) ? HI_W : LO_W;
    localparam logic [WIDTH-1:0] LAST  = (METHOD == 1) ? LO_W : HI_W;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SPAN - 1);
    localparam logic [15:0]   LFSR_SEED = 16'hACE1;
    localparam logic [31:0]   LO32      = 32'(LOWER_BOUND);
    localparam logic [31:0]   HI32      = 32'(UPPER_BOUND);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [WIDTH-1:0]  dat_nxt;
    logic              valid_nxt;
    logic              wrap_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_nxt;
    logic [15:0]       lfsr_step;

    logic              accept;
    logic              last_beat;
    logic              end_pass;

    function automatic logic in_range(input logic [WIDTH-1:0] v);
        logic [31:0] v32;
        v32 = 32'(v);
        return (v32 >= LO32) && (v32 < HI32);
    endfunction

    // Taps 16,14,13,11 counted from the output end of a right shift.
    assign lfsr_step = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    // valid is only ever high in RUN, so accept implies RUN.
    assign accept    = valid & ready;
    assign last_beat = (METHOD == 2) ? (cnt == CNT_LAST) : (dat == LAST);
    assign end_pass  = accept & last_beat;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic; halt has priority over start and over acceptance
    // ---------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!halt && start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    state_nxt = IDLE;
                end else if (end_pass && (ONE_SHOT != 0)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (halt) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output logic: next values of the registered outputs and datapath
    // ---------------------------------------------------------------------
    always_comb begin
        dat_nxt   = dat;
        valid_nxt = valid;
        wrap_nxt  = 1'b0;
        cnt_nxt   = cnt;
        lfsr_nxt  = lfsr;

        if (halt) begin
            // Sweep position and counter clear; the LFSR keeps its state.
            valid_nxt = 1'b0;
            dat_nxt   = LO_W;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cnt_nxt = '0;
                        if (METHOD == 2) begin
                            // Present the current LFSR state without stepping,
                            // so a restart continues where the last run stopped.
                            dat_nxt   = lfsr[WIDTH-1:0];
                            valid_nxt = in_range(lfsr[WIDTH-1:0]);
                        end else begin
                            dat_nxt   = FIRST;
                            valid_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (METHOD == 2) begin
                        if (accept) begin
                            wrap_nxt = last_beat;
                            cnt_nxt  = last_beat ? '0 : cnt + 1'b1;
                        end
                        // Step whenever nothing is waiting for the consumer.
                        if (!valid || ready) begin
                            lfsr_nxt  = lfsr_step;
                            dat_nxt   = lfsr_step[WIDTH-1:0];
                            valid_nxt = in_range(lfsr_step[WIDTH-1:0]);
                        end
                    end else if (accept) begin
                        wrap_nxt = last_beat;
                        if (last_beat) begin
                            dat_nxt = FIRST;
                        end else if (METHOD == 1) begin
                            dat_nxt = dat - 1'b1;
                        end else begin
                            dat_nxt = dat + 1'b1;
                        end
                    end
                    if (end_pass && (ONE_SHOT != 0)) begin
                        valid_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
    end

    // ---------------------------------------------------------------------
    // Output and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            dat   <= LO_W;
            valid <= 1'b0;
            wrap  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            lfsr  <= LFSR_SEED;
        end else begin
            dat   <= dat_nxt;
            valid <= valid_nxt;
            wrap  <= wrap_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            cnt   <= cnt_nxt;
            lfsr  <= lfsr_nxt;
        end
    end

endmodule

// File: tb/tb_range_gen.sv
// ---------------------------------------------------------------------------
// tb_range_gen
//
// Four range_gen instances share clk and arst:
//   u0 : defaults, ascending sweep 85..119
//   u1 : descending sweep, one-shot
//   u2 : pseudo-random over 85..119
//   u3 : WIDTH=4, single-value range {15}
// Stimulus pushes the expected accepted beats (value + wrap flag) into a
// per-instance queue; a monitor on the falling edge pops and compares on
// every accepted beat and also checks range, wrap timing and hold stability.
// ---------------------------------------------------------------------------
module tb_range_gen;

    typedef struct packed {
        logic [15:0] val;
        logic        wr;
    } exp_t;

    logic        clk;
    logic        arst;
    logic        st  [4];
    logic        hl  [4];
    logic        rdy [4];
    logic        vld [4];
    logic        bsy [4];
    logic        wrp [4];
    logic        dn  [4];
    logic [15:0] dw  [4];

    logic [6:0]  dat0;
    logic [6:0]  dat1;
    logic [6:0]  dat2;
    logic [3:0]  dat3;

    assign dw[0] = 16'(dat0);
    assign dw[1] = 16'(dat1);
    assign dw[2] = 16'(dat2);
    assign dw[3] = 16'(dat3);

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    int checks = 0;
    int errors = 0;
    int acc  [4];
    int wcnt [4];
    bit pend [4];
    bit hold [4];
    logic [15:0] hold_dat [4];

    range_gen #(.WIDTH(7), .LOWER_BOUND(85), .UPPER_BOUND(120), .METHOD(0), .ONE_SHOT(0)) u0 (
        .clk(clk), .arst(arst), .start(st[0]), .halt(hl[0]), .dat(dat0), .valid(vld[0]),
        .ready(rdy[0]), .busy(bsy[0]), .wrap(wrp[0]), .done(dn[0]));
    range_gen #(.WIDTH(7), .LOWER_BOUND(85), .UPPER_BOUND(120), .METHOD(1), .ONE_SHOT(1)) u1 (
        .clk(clk), .arst(arst), .start(st[1]), .halt(hl[1]), .dat(dat1), .valid(vld[1]),
        .ready(rdy[1]), .busy(bsy[1]), .wrap(wrp[1]), .done(dn[1]));
    range_gen #(.WIDTH(7), .LOWER_BOUND(85), .UPPER_BOUND(120), .METHOD(2), .ONE_SHOT(0)) u2 (
        .clk(clk), .arst(arst), .start(st[2]), .halt(hl[2]), .dat(dat2), .valid(vld[2]),
        .ready(rdy[2]), .busy(bsy[2]), .wrap(wrp[2]), .done(dn[2]));
    range_gen #(.WIDTH(4), .LOWER_BOUND(15), .UPPER_BOUND(16), .METHOD(0), .ONE_SHOT(0)) u3 (
        .clk(clk), .arst(arst), .start(st[3]), .halt(hl[3]), .dat(dat3), .valid(vld[3]),
        .ready(rdy[3]), .busy(bsy[3]), .wrap(wrp[3]), .done(dn[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lo_of(input int k);
        return (k == 3) ? 15 : 85;
    endfunction

    function automatic int hi_of(input int k);
        return (k == 3) ? 16 : 120;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int k, input int v, input bit w);
        exp_t e;
        e.val = 16'(v);
        e.wr  = w;
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int k, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '0;
        case (k)
            0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            2: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
            default: if (q3.size() > 0) e = q3.pop_front(); else ok = 1'b0;
        endcase
    endtask

    // Monitor: falling edge, inputs and outputs are stable here.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (arst) begin
                pend[k] = 1'b0;
                hold[k] = 1'b0;
            end else begin
                exp_t e;
                bit   ok;
                check($sformatf("u%0d_wrap", k), 32'(wrp[k]), 32'(pend[k]));
                if (wrp[k]) wcnt[k]++;
                if (hold[k]) begin
                    check($sformatf("u%0d_hold_valid", k), 32'(vld[k]), 32'd1);
                    check($sformatf("u%0d_hold_dat", k), 32'(dw[k]), 32'(hold_dat[k]));
                end
                pend[k] = 1'b0;
                if (vld[k]) begin
                    check($sformatf("u%0d_range", k),
                          32'((int'(dw[k]) >= lo_of(k)) && (int'(dw[k]) < hi_of(k))), 32'd1);
                end
                if (vld[k] && rdy[k] && !hl[k]) begin
                    pop_exp(k, e, ok);
                    if (!ok) begin
                        checks++;
                        errors++;
                        $display("FAIL u%0d_unexpected_beat actual=%0d required=no beat", k, dw[k]);
                    end else begin
                        check($sformatf("u%0d_dat", k), 32'(dw[k]), 32'(e.val));
                        pend[k] = e.wr;
                    end
                    acc[k]++;
                end
                hold[k]     = vld[k] && !rdy[k] && !hl[k];
                hold_dat[k] = dw[k];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int k);
        st[k] = 1'b1;
        tick();
        st[k] = 1'b0;
    endtask

    task automatic do_halt(input int k);
        rdy[k] = 1'b0;
        hl[k]  = 1'b1;
        tick();
        hl[k]  = 1'b0;
    endtask

    // Runs until acc[k] reaches target (bounded); ready goes low once it does.
    task automatic wait_acc(input int k, input int target, input int budget, input bit rnd,
                            output int cyc);
        cyc = 0;
        while (acc[k] < target && cyc < budget) begin
            tick();
            cyc++;
            if (acc[k] >= target) rdy[k] = 1'b0;
            else rdy[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        rdy[k] = 1'b0;
        check($sformatf("u%0d_accept_count", k), 32'(acc[k]), 32'(target));
    endtask

    initial begin
        int cyc;
        int base;
        logic [15:0] lf;
        int pushed;

        arst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            st[k] = 1'b0; hl[k] = 1'b0; rdy[k] = 1'b0;
            acc[k] = 0; wcnt[k] = 0; pend[k] = 1'b0; hold[k] = 1'b0; hold_dat[k] = '0;
        end

        // Reset state
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("u%0d_rst_valid", k), 32'(vld[k]), 32'd0);
            check($sformatf("u%0d_rst_busy", k), 32'(bsy[k]), 32'd0);
            check($sformatf("u%0d_rst_wrap", k), 32'(wrp[k]), 32'd0);
            check($sformatf("u%0d_rst_done", k), 32'(dn[k]), 32'd0);
            check($sformatf("u%0d_rst_dat", k), 32'(dw[k]), 32'(lo_of(k)));
        end
        tick(); tick();
        arst = 1'b0;
        tick(); tick();
        check("u0_idle_after_reset", 32'(vld[0]), 32'd0);

        // u0: ascending sweep, ready=1, no bubbles across the wrap
        for (int v = 85; v < 120; v++) push_exp(0, v, v == 119);
        push_exp(0, 85, 1'b0);
        push_exp(0, 86, 1'b0);
        rdy[0] = 1'b1;
        pulse_start(0);
        check("u0_first_valid", 32'(vld[0]), 32'd1);
        check("u0_first_dat", 32'(dw[0]), 32'd85);
        check("u0_busy", 32'(bsy[0]), 32'd1);
        wait_acc(0, 37, 200, 1'b0, cyc);
        check("u0_no_bubble_cycles", 32'(cyc), 32'd37);
        check("u0_next_dat", 32'(dw[0]), 32'd87);
        do_halt(0);
        check("u0_halt_valid", 32'(vld[0]), 32'd0);
        check("u0_halt_busy", 32'(bsy[0]), 32'd0);
        check("u0_halt_dat", 32'(dw[0]), 32'd85);

        // u0: random ready, sweep restarts from 85
        for (int p = 0; p < 2; p++)
            for (int v = 85; v < 120; v++) push_exp(0, v, v == 119);
        push_exp(0, 85, 1'b0);
        push_exp(0, 86, 1'b0);
        rdy[0] = 1'($urandom_range(0, 1));
        pulse_start(0);
        wait_acc(0, 37 + 72, 3000, 1'b1, cyc);
        check("u0_queue_empty", 32'(q0.size()), 32'd0);

        // halt and start together in RUN -> IDLE
        st[0] = 1'b1; hl[0] = 1'b1;
        tick();
        st[0] = 1'b0; hl[0] = 1'b0;
        check("u0_halt_start_valid", 32'(vld[0]), 32'd0);
        check("u0_halt_start_busy", 32'(bsy[0]), 32'd0);
        check("u0_halt_start_done", 32'(dn[0]), 32'd0);
        tick();
        check("u0_stays_idle", 32'(vld[0]), 32'd0);

        // u1: descending one-shot, then restart
        for (int p = 0; p < 2; p++) begin
            for (int v = 119; v >= 85; v--) push_exp(1, v, v == 85);
            rdy[1] = 1'b1;
            pulse_start(1);
            check("u1_first_valid", 32'(vld[1]), 32'd1);
            check("u1_first_dat", 32'(dw[1]), 32'd119);
            check("u1_busy", 32'(bsy[1]), 32'd1);
            wait_acc(1, 35 * (p + 1), 100, 1'b0, cyc);
            check("u1_pass_cycles", 32'(cyc), 32'd35);
            check("u1_done", 32'(dn[1]), 32'd1);
            check("u1_done_busy", 32'(bsy[1]), 32'd0);
            check("u1_done_valid", 32'(vld[1]), 32'd0);
            tick();
            check("u1_done_level", 32'(dn[1]), 32'd1);
        end

        // u3: single-value range, wrap on every acceptance
        for (int i = 0; i < 12; i++) push_exp(3, 15, 1'b1);
        rdy[3] = 1'($urandom_range(0, 1));
        pulse_start(3);
        wait_acc(3, 12, 500, 1'b1, cyc);
        tick();
        check("u3_wrap_count", 32'(wcnt[3]), 32'd12);
        do_halt(3);

        // u2: pseudo-random; expected sequence is the filtered LFSR stream
        lf = 16'hACE1;
        pushed = 0;
        while (pushed < 1600) begin
            if (lf[6:0] >= 7'd85 && lf[6:0] < 7'd120) begin
                push_exp(2, int'(lf[6:0]), ((pushed + 1) % 35) == 0);
                pushed++;
            end
            lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
        end
        rdy[2] = 1'($urandom_range(0, 1));
        pulse_start(2);
        wait_acc(2, 1400, 14000, 1'b1, cyc);
        tick();
        check("u2_wrap_count", 32'(wcnt[2]), 32'(acc[2] / 35));
        do_halt(2);

        // Asynchronous reset mid-RUN
        base = acc[0];
        for (int v = 85; v < 95; v++) push_exp(0, v, 1'b0);
        rdy[0] = 1'b1;
        pulse_start(0);
        wait_acc(0, base + 5, 100, 1'b0, cyc);
        check("u0_pre_reset_valid", 32'(vld[0]), 32'd1);
        #1;
        arst = 1'b1;
        #1;
        check("u0_async_valid", 32'(vld[0]), 32'd0);
        check("u0_async_dat", 32'(dw[0]), 32'd85);
        check("u0_async_busy", 32'(bsy[0]), 32'd0);
        tick();
        arst = 1'b0;
        q0.delete();
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("u%0d_post_reset_valid", k), 32'(vld[k]), 32'd0);
            check($sformatf("u%0d_post_reset_busy", k), 32'(bsy[k]), 32'd0);
            check($sformatf("u%0d_post_reset_done", k), 32'(dn[k]), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
